// File: rtl/nrs_pingpong_gen.sv
// NB-IoT NRS generator: per-slot Gold sequence, QPSK map, ping-pong store.
// Slot n+1 is generated in the back bank while both read ports see slot n.
module nrs_pingpong_gen #(
    parameter int WIDTH_B       = 9,
    parameter int NRS_WIDTH_R_I = 16,
    parameter int AMP           = 23170,
    parameter int N_SLOTS       = 20
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            new_frame,
    input  logic                            slot_tick,
    input  logic [WIDTH_B-1:0]              N_cell_ID,
    input  logic [1:0]                      rd_addr_est,
    input  logic [1:0]                      rd_addr_fine,
    output logic signed [NRS_WIDTH_R_I-1:0] nrs_est_i,
    output logic signed [NRS_WIDTH_R_I-1:0] nrs_est_q,
    output logic signed [NRS_WIDTH_R_I-1:0] nrs_fine_i,
    output logic signed [NRS_WIDTH_R_I-1:0] nrs_fine_q,
    output logic                            active_valid,
    output logic [4:0]                      active_slot,
    output logic                            gen_ready,
    output logic                            overrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_LOAD,
        S_SKIP,
        S_CAPT,
        S_DONE
    } state_t;

    localparam int ACC_W = 8 + WIDTH_B + 1;
    localparam logic [10:0] SKIP_LAST = 11'd1817;
    localparam logic signed [NRS_WIDTH_R_I-1:0] POS = NRS_WIDTH_R_I'(AMP);
    localparam logic signed [NRS_WIDTH_R_I-1:0] NEG = -POS;

    state_t             state;
    logic [WIDTH_B-1:0] nid;
    logic [4:0]         gen_slot;
    logic               sym;
    logic [10:0]        cnt;
    logic [ACC_W-1:0]   acc;
    logic [30:0]        x1;
    logic [30:0]        x2;
    logic [7:0]         bank [2];
    logic               act;

    logic [WIDTH_B:0] id_odd;
    logic [7:0]       factor;
    logic [30:0]      cinit;
    logic             c_bit;
    logic [4:0]       slot_nxt;
    logic             kick;
    logic [7:0]       act_byte;

    // Multiplier operands, c_init, Gold output bit and event decode
    always_comb begin
        id_odd   = {nid, 1'b1};
        factor   = {gen_slot, 3'b000} - {3'b000, gen_slot}
                 + 8'd13 + {7'b0, sym};
        cinit    = 31'({acc, 10'b0}) + 31'(id_odd);
        c_bit    = x1[0] ^ x2[0];
        slot_nxt = (gen_slot == 5'(N_SLOTS - 1)) ? 5'd0 : gen_slot + 5'd1;
        kick     = new_frame
                 | (slot_tick & (gen_ready | (state != S_IDLE)));
        act_byte = bank[act];
    end

    // Event handling and the generation FSM (MUL/LOAD/SKIP/CAPT per symbol)
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            nid          <= '0;
            gen_slot     <= '0;
            sym          <= 1'b0;
            cnt          <= '0;
            acc          <= '0;
            x1           <= '0;
            x2           <= '0;
            bank[0]      <= '0;
            bank[1]      <= '0;
            act          <= 1'b0;
            active_valid <= 1'b0;
            active_slot  <= '0;
            gen_ready    <= 1'b0;
            overrun      <= 1'b0;
        end else if (kick) begin
            state     <= S_MUL;
            sym       <= 1'b0;
            cnt       <= '0;
            acc       <= '0;
            gen_ready <= 1'b0;
            if (new_frame) begin
                nid          <= N_cell_ID;
                gen_slot     <= '0;
                active_valid <= 1'b0;
                overrun      <= 1'b0;
            end else if (gen_ready) begin
                act          <= ~act;
                active_slot  <= gen_slot;
                active_valid <= 1'b1;
                gen_slot     <= slot_nxt;
            end else begin
                active_valid <= 1'b0;
                overrun      <= 1'b1;
                gen_slot     <= slot_nxt;
            end
        end else begin
            unique case (state)
                S_MUL: begin
                    if (id_odd[cnt[3:0]])
                        acc <= acc + (ACC_W'(factor) << cnt[3:0]);
                    if (cnt == 11'(WIDTH_B)) begin
                        state <= S_LOAD;
                    end else begin
                        cnt <= cnt + 11'd1;
                    end
                end
                S_LOAD: begin
                    x1    <= 31'd1;
                    x2    <= cinit;
                    cnt   <= '0;
                    state <= S_SKIP;
                end
                S_SKIP: begin
                    x1 <= {x1[3] ^ x1[0], x1[30:1]};
                    x2 <= {x2[3] ^ x2[2] ^ x2[1] ^ x2[0], x2[30:1]};
                    if (cnt == SKIP_LAST) begin
                        cnt   <= '0;
                        state <= S_CAPT;
                    end else begin
                        cnt <= cnt + 11'd1;
                    end
                end
                S_CAPT: begin
                    bank[~act][{sym, cnt[1:0]}] <= c_bit;
                    x1 <= {x1[3] ^ x1[0], x1[30:1]};
                    x2 <= {x2[3] ^ x2[2] ^ x2[1] ^ x2[0], x2[30:1]};
                    if (cnt == 11'd3) begin
                        cnt <= '0;
                        if (sym) begin
                            state <= S_DONE;
                        end else begin
                            sym   <= 1'b1;
                            acc   <= '0;
                            state <= S_MUL;
                        end
                    end else begin
                        cnt <= cnt + 11'd1;
                    end
                end
                S_DONE: begin
                    gen_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Registered read ports; bit index is {sym, m, q} into the active bank
    always_ff @(posedge clk) begin
        if (rst || !active_valid) begin
            nrs_est_i  <= '0;
            nrs_est_q  <= '0;
            nrs_fine_i <= '0;
            nrs_fine_q <= '0;
        end else begin
            nrs_est_i  <= act_byte[{rd_addr_est, 1'b0}] ? NEG : POS;
            nrs_est_q  <= act_byte[{rd_addr_est, 1'b1}] ? NEG : POS;
            nrs_fine_i <= act_byte[{rd_addr_fine, 1'b0}] ? NEG : POS;
            nrs_fine_q <= act_byte[{rd_addr_fine, 1'b1}] ? NEG : POS;
        end
    end

endmodule

// File: tb/tb_nrs_pingpong_gen.sv
// Directed bench for nrs_pingpong_gen with a reference Gold sequence model.
// Checks reset, latency, data, slot wrap, overrun, event priority, mid-run rst.
module tb_nrs_pingpong_gen;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               new_frame = 1'b0;
    logic               slot_tick = 1'b0;
    logic [8:0]         N_cell_ID = '0;
    logic [1:0]         rd_addr_est = '0;
    logic [1:0]         rd_addr_fine = '0;
    logic signed [15:0] nrs_est_i, nrs_est_q, nrs_fine_i, nrs_fine_q;
    logic               active_valid;
    logic [4:0]         active_slot;
    logic               gen_ready;
    logic               overrun;

    int vecs = 0;
    int errs = 0;

    nrs_pingpong_gen dut (
        .clk          (clk),
        .rst          (rst),
        .new_frame    (new_frame),
        .slot_tick    (slot_tick),
        .N_cell_ID    (N_cell_ID),
        .rd_addr_est  (rd_addr_est),
        .rd_addr_fine (rd_addr_fine),
        .nrs_est_i    (nrs_est_i),
        .nrs_est_q    (nrs_est_q),
        .nrs_fine_i   (nrs_fine_i),
        .nrs_fine_q   (nrs_fine_q),
        .active_valid (active_valid),
        .active_slot  (active_slot),
        .gen_ready    (gen_ready),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: c(n) = x1(n+1600) ^ x2(n+1600), returns c(218..221)
    function automatic logic [3:0] gold4(input logic [30:0] ci);
        logic x1 [0:1821];
        logic x2 [0:1821];
        logic [3:0] r;
        for (int n = 0; n < 31; n++) begin
            x1[n] = (n == 0);
            x2[n] = ci[n];
        end
        for (int n = 0; n < 1791; n++) begin
            x1[n+31] = x1[n+3] ^ x1[n];
            x2[n+31] = x2[n+3] ^ x2[n+2] ^ x2[n+1] ^ x2[n];
        end
        for (int k = 0; k < 4; k++) r[k] = x1[1818+k] ^ x2[1818+k];
        return r;
    endfunction

    function automatic logic [30:0] cinit_of(input int ns, input int l,
                                             input int id);
        return 31'(1024 * (7 * (ns + 1) + l + 1) * (2 * id + 1) + 2 * id + 1);
    endfunction

    function automatic logic [31:0] amp(input logic b);
        return b ? 32'h0000_A57E : 32'd23170;
    endfunction

    task automatic pulse(input logic nf, input logic st);
        @(negedge clk);
        new_frame = nf;
        slot_tick = st;
        @(negedge clk);
        new_frame = 1'b0;
        slot_tick = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!gen_ready && n < 5000);
    endtask

    task automatic check_slot(input string tag, input logic [30:0] c5,
                              input logic [30:0] c6);
        logic [7:0] e;
        e = {gold4(c6), gold4(c5)};
        for (int a = 0; a < 4; a++) begin
            logic [1:0] ae;
            logic [1:0] af;
            ae = 2'(a);
            af = ~ae;
            @(negedge clk);
            rd_addr_est  = ae;
            rd_addr_fine = af;
            @(posedge clk);
            #1;
            chk($sformatf("%s est_i a%0d", tag, ae), {16'b0, nrs_est_i},
                amp(e[{ae, 1'b0}]));
            chk($sformatf("%s est_q a%0d", tag, ae), {16'b0, nrs_est_q},
                amp(e[{ae, 1'b1}]));
            chk($sformatf("%s fine_i a%0d", tag, af), {16'b0, nrs_fine_i},
                amp(e[{af, 1'b0}]));
            chk($sformatf("%s fine_q a%0d", tag, af), {16'b0, nrs_fine_q},
                amp(e[{af, 1'b1}]));
        end
    endtask

    task automatic check_zero(input string tag);
        for (int a = 0; a < 4; a++) begin
            @(negedge clk);
            rd_addr_est  = 2'(a);
            rd_addr_fine = 2'(3 - a);
            @(posedge clk);
            #1;
            chk({tag, " est_i"}, {16'b0, nrs_est_i}, 32'd0);
            chk({tag, " est_q"}, {16'b0, nrs_est_q}, 32'd0);
            chk({tag, " fine_i"}, {16'b0, nrs_fine_i}, 32'd0);
            chk({tag, " fine_q"}, {16'b0, nrs_fine_q}, 32'd0);
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, " est_i"}, {16'b0, nrs_est_i}, 32'd0);
        chk({tag, " est_q"}, {16'b0, nrs_est_q}, 32'd0);
        chk({tag, " fine_i"}, {16'b0, nrs_fine_i}, 32'd0);
        chk({tag, " fine_q"}, {16'b0, nrs_fine_q}, 32'd0);
        chk({tag, " valid"}, {31'b0, active_valid}, 32'd0);
        chk({tag, " slot"}, {27'b0, active_slot}, 32'd0);
        chk({tag, " ready"}, {31'b0, gen_ready}, 32'd0);
        chk({tag, " overrun"}, {31'b0, overrun}, 32'd0);
    endtask

    initial begin
        int n;
        int sl [3];
        logic [30:0] c6;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        check_reset_state("reset");

        pulse(1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("tick pre-frame ready", {31'b0, gen_ready}, 32'd0);
        chk("tick pre-frame valid", {31'b0, active_valid}, 32'd0);
        chk("tick pre-frame overrun", {31'b0, overrun}, 32'd0);

        N_cell_ID = 9'd0;
        pulse(1'b1, 1'b0);
        wait_ready(n);
        chk("latency id0", n, 32'd3667);
        pulse(1'b0, 1'b1);
        @(posedge clk);
        #1;
        chk("id0 valid", {31'b0, active_valid}, 32'd1);
        chk("id0 slot", {27'b0, active_slot}, 32'd0);
        chk("id0 ready cleared", {31'b0, gen_ready}, 32'd0);
        check_slot("id0 s0", 31'd13313, 31'd14337);

        N_cell_ID = 9'd503;
        pulse(1'b1, 1'b0);
        N_cell_ID = 9'd42;
        chk("nf clears valid", {31'b0, active_valid}, 32'd0);
        for (int s = 0; s < 3; s++) begin
            wait_ready(n);
            chk($sformatf("503 ready s%0d", s), {31'b0, gen_ready}, 32'd1);
            pulse(1'b0, 1'b1);
            @(posedge clk);
            #1;
            chk($sformatf("503 slot s%0d", s), {27'b0, active_slot}, 32'(s));
            chk($sformatf("503 valid s%0d", s), {31'b0, active_valid}, 32'd1);
            check_slot($sformatf("503 s%0d", s), cinit_of(s, 5, 503),
                       cinit_of(s, 6, 503));
        end

        repeat (2000) @(posedge clk);
        pulse(1'b0, 1'b1);
        @(posedge clk);
        #1;
        chk("ovr overrun", {31'b0, overrun}, 32'd1);
        chk("ovr valid", {31'b0, active_valid}, 32'd0);
        chk("ovr no swap", {27'b0, active_slot}, 32'd2);
        chk("ovr ready", {31'b0, gen_ready}, 32'd0);
        check_zero("ovr rd");

        for (int i = 0; i < 14; i++) begin
            repeat (20) @(posedge clk);
            pulse(1'b0, 1'b1);
        end
        wait_ready(n);
        chk("ffwd latency", n, 32'd3667);

        sl = '{18, 19, 0};
        for (int i = 0; i < 3; i++) begin
            pulse(1'b0, 1'b1);
            @(posedge clk);
            #1;
            chk($sformatf("wrap slot i%0d", i), {27'b0, active_slot},
                32'(sl[i]));
            chk($sformatf("wrap valid i%0d", i), {31'b0, active_valid}, 32'd1);
            chk($sformatf("wrap overrun i%0d", i), {31'b0, overrun}, 32'd1);
            c6 = (sl[i] == 19) ? 31'd151582703 : cinit_of(sl[i], 6, 503);
            check_slot($sformatf("503 s%0d", sl[i]), cinit_of(sl[i], 5, 503),
                       c6);
            wait_ready(n);
            chk($sformatf("wrap ready i%0d", i), {31'b0, gen_ready}, 32'd1);
        end

        N_cell_ID = 9'd7;
        pulse(1'b1, 1'b1);
        N_cell_ID = 9'd100;
        chk("both overrun", {31'b0, overrun}, 32'd0);
        chk("both valid", {31'b0, active_valid}, 32'd0);
        chk("both ready", {31'b0, gen_ready}, 32'd0);
        wait_ready(n);
        chk("both latency", n, 32'd3667);
        pulse(1'b0, 1'b1);
        @(posedge clk);
        #1;
        chk("both slot", {27'b0, active_slot}, 32'd0);
        chk("both valid after", {31'b0, active_valid}, 32'd1);
        check_slot("id7 s0", cinit_of(0, 5, 7), cinit_of(0, 6, 7));

        N_cell_ID = 9'd0;
        pulse(1'b1, 1'b0);
        repeat (1000) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_state("midrst");
        repeat (10) @(posedge clk);
        #1;
        chk("midrst idle", {31'b0, gen_ready}, 32'd0);
        pulse(1'b1, 1'b0);
        wait_ready(n);
        chk("rerun latency", n, 32'd3667);
        pulse(1'b0, 1'b1);
        @(posedge clk);
        #1;
        chk("rerun slot", {27'b0, active_slot}, 32'd0);
        check_slot("rerun s0", 31'd13313, 31'd14337);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
